mem_read_arbi_n: RTL and testbench



---
 rtl/mem_read_arbi_n.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_read_arbi_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbi_n.sv
// N-channel burst read arbiter in front of a single DDR3 controller read port.
// Round-robin or fixed-priority grant, per-burst watchdog, one-hot grant status.
module mem_read_arbi_n #(
    parameter int unsigned MEM_DATA_BITS  = 32,
    parameter int unsigned ADDR_BITS      = 23,
    parameter int unsigned BURST_BITS     = 10,
    parameter int unsigned CH_NUM         = 6,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic                              mem_clk,
    input  logic                              rst_n,

    input  logic [CH_NUM-1:0]                 ch_rd_burst_req,
    input  logic [CH_NUM*BURST_BITS-1:0]      ch_rd_burst_len,
    input  logic [CH_NUM*ADDR_BITS-1:0]       ch_rd_burst_addr,
    output logic [CH_NUM-1:0]                 ch_rd_burst_data_valid,
    output logic [CH_NUM*MEM_DATA_BITS-1:0]   ch_rd_burst_data,
    output logic [CH_NUM-1:0]                 ch_rd_burst_finish,
    output logic [CH_NUM-1:0]                 ch_rd_burst_timeout,

    output logic [CH_NUM-1:0]                 grant,
    output logic                              busy,

    output logic                              rd_burst_req,
    output logic [BURST_BITS-1:0]             rd_burst_len,
    output logic [ADDR_BITS-1:0]              rd_burst_addr,
    input  logic                              rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0]          rd_burst_data,
    input  logic                              rd_burst_finish
);

    localparam int unsigned SEL_BITS = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [SEL_BITS-1:0] LAST_CH = SEL_BITS'(CH_NUM - 1);
    // The counter is 16 bits wide; a limit it cannot reach leaves the watchdog off.
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0) && (TIMEOUT_CYCLES <= 65535);
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StBegin,
        StRead,
        StEnd
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_BITS-1:0]    sel_q, sel_d;
    logic [SEL_BITS-1:0]    last_q, last_d;
    logic [CH_NUM-1:0]      grant_q, grant_d;
    logic                   req_q, req_d;
    logic [BURST_BITS-1:0]  len_q, len_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [15:0]            wdog_q, wdog_d;
    logic [CH_NUM-1:0]      finish_q, finish_d;
    logic [CH_NUM-1:0]      timeout_q, timeout_d;

    logic [CH_NUM-1:0]      eligible;
    logic                   win_found;
    logic [SEL_BITS-1:0]    win_idx;
    logic [CH_NUM-1:0]      win_onehot;
    logic [CH_NUM-1:0]      sel_onehot;
    logic [BURST_BITS-1:0]  sel_len;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic                   route_en;
    logic                   wdog_hit;
    int unsigned            rr_idx;

    always_comb begin
        for (int i = 0; i < int'(CH_NUM); i++) begin
            eligible[i] = ch_rd_burst_req[i] &&
                          (ch_rd_burst_len[i*BURST_BITS +: BURST_BITS] != '0);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        if (ARB_MODE != 0) begin
            // Scan downwards so the lowest eligible index is the last one written.
            for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    win_found = 1'b1;
                    win_idx   = SEL_BITS'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= CH_NUM; k++) begin
                rr_idx = 32'(last_q) + k;
                if (rr_idx >= CH_NUM) begin
                    rr_idx = rr_idx - CH_NUM;
                end
                if (!win_found && eligible[rr_idx]) begin
                    win_found = 1'b1;
                    win_idx   = SEL_BITS'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(CH_NUM); i++) begin
            win_onehot[i] = (win_idx == SEL_BITS'(i));
            sel_onehot[i] = (sel_q == SEL_BITS'(i));
        end
    end

    always_comb begin
        sel_len  = '0;
        sel_addr = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (sel_onehot[i]) begin
                sel_len  = ch_rd_burst_len[i*BURST_BITS +: BURST_BITS];
                sel_addr = ch_rd_burst_addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    assign wdog_hit = WDOG_EN && (wdog_q == WDOG_LIMIT);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        grant_d   = grant_q;
        req_d     = req_q;
        len_d     = len_q;
        addr_d    = addr_q;
        wdog_d    = wdog_q;
        finish_d  = '0;
        timeout_d = '0;

        unique case (state_q)
            StIdle: begin
                state_d = StArb;
            end
            StArb: begin
                grant_d = '0;
                if (win_found) begin
                    sel_d   = win_idx;
                    grant_d = win_onehot;
                    wdog_d  = '0;
                    state_d = StBegin;
                end
            end
            StBegin: begin
                len_d   = sel_len;
                addr_d  = sel_addr;
                req_d   = 1'b1;
                wdog_d  = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
                state_d = StRead;
            end
            StRead: begin
                wdog_d = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
                if (rd_burst_data_valid) begin
                    req_d = 1'b0;
                end
                // A finish arriving on the watchdog's last cycle still completes normally.
                if (rd_burst_finish) begin
                    req_d    = 1'b0;
                    finish_d = sel_onehot;
                    state_d  = StEnd;
                end else if (wdog_hit) begin
                    req_d     = 1'b0;
                    timeout_d = sel_onehot;
                    last_d    = sel_q;
                    grant_d   = '0;
                    state_d   = StArb;
                end
            end
            StEnd: begin
                last_d  = sel_q;
                grant_d = '0;
                state_d = StArb;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (CH_NUM == 1) begin
            last_d = '0;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            last_q    <= LAST_CH;
            grant_q   <= '0;
            req_q     <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            wdog_q    <= '0;
            finish_q  <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            req_q     <= req_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            wdog_q    <= wdog_d;
            finish_q  <= finish_d;
            timeout_q <= timeout_d;
        end
    end

    assign route_en = (state_q == StRead) || (state_q == StEnd);

    always_comb begin
        ch_rd_burst_data_valid = '0;
        ch_rd_burst_data       = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (route_en && sel_onehot[i]) begin
                ch_rd_burst_data_valid[i]                       = rd_burst_data_valid;
                ch_rd_burst_data[i*MEM_DATA_BITS +: MEM_DATA_BITS] = rd_burst_data;
            end
        end
    end

    assign ch_rd_burst_finish  = finish_q;
    assign ch_rd_burst_timeout = timeout_q;
    assign grant               = grant_q;
    assign busy                = (state_q == StBegin) || (state_q == StRead) ||
                                 (state_q == StEnd);
    assign rd_burst_req        = req_q;
    assign rd_burst_len        = len_q;
    assign rd_burst_addr       = addr_q;

endmodule

// File: tb/tb_mem_read_arbi_n.sv
// Directed bench for mem_read_arbi_n: a round-robin instance with a 100-cycle
// watchdog and a fixed-priority instance, both on one clock and reset.
module tb_mem_read_arbi_n;

    localparam int RR_CH = 6;
    localparam int FP_CH = 4;

    logic mem_clk = 1'b0;
    logic rst_n;

    always #5 mem_clk = ~mem_clk;

    logic [RR_CH-1:0]    rr_req;
    logic [RR_CH*10-1:0] rr_len;
    logic [RR_CH*23-1:0] rr_addr;
    logic [RR_CH-1:0]    rr_ch_valid, rr_ch_finish, rr_ch_timeout, rr_grant;
    logic [RR_CH*32-1:0] rr_ch_data;
    logic                rr_busy, rr_rd_burst_req;
    logic [9:0]          rr_rd_burst_len;
    logic [22:0]         rr_rd_burst_addr;
    logic                rr_mem_valid, rr_mem_finish;
    logic [31:0]         rr_mem_data;

    logic [FP_CH-1:0]    fp_req;
    logic [FP_CH*10-1:0] fp_len;
    logic [FP_CH*23-1:0] fp_addr;
    logic [FP_CH-1:0]    fp_ch_valid, fp_ch_finish, fp_ch_timeout, fp_grant;
    logic [FP_CH*32-1:0] fp_ch_data;
    logic                fp_busy, fp_rd_burst_req;
    logic [9:0]          fp_rd_burst_len;
    logic [22:0]         fp_rd_burst_addr;
    logic                fp_mem_valid, fp_mem_finish;
    logic [31:0]         fp_mem_data;

    mem_read_arbi_n #(
        .MEM_DATA_BITS (32),
        .ADDR_BITS     (23),
        .BURST_BITS    (10),
        .CH_NUM        (RR_CH),
        .ARB_MODE      (0),
        .TIMEOUT_CYCLES(100)
    ) dut_rr (
        .mem_clk               (mem_clk),
        .rst_n                 (rst_n),
        .ch_rd_burst_req       (rr_req),
        .ch_rd_burst_len       (rr_len),
        .ch_rd_burst_addr      (rr_addr),
        .ch_rd_burst_data_valid(rr_ch_valid),
        .ch_rd_burst_data      (rr_ch_data),
        .ch_rd_burst_finish    (rr_ch_finish),
        .ch_rd_burst_timeout   (rr_ch_timeout),
        .grant                 (rr_grant),
        .busy                  (rr_busy),
        .rd_burst_req          (rr_rd_burst_req),
        .rd_burst_len          (rr_rd_burst_len),
        .rd_burst_addr         (rr_rd_burst_addr),
        .rd_burst_data_valid   (rr_mem_valid),
        .rd_burst_data         (rr_mem_data),
        .rd_burst_finish       (rr_mem_finish)
    );

    mem_read_arbi_n #(
        .MEM_DATA_BITS (32),
        .ADDR_BITS     (23),
        .BURST_BITS    (10),
        .CH_NUM        (FP_CH),
        .ARB_MODE      (1),
        .TIMEOUT_CYCLES(0)
    ) dut_fp (
        .mem_clk               (mem_clk),
        .rst_n                 (rst_n),
        .ch_rd_burst_req       (fp_req),
        .ch_rd_burst_len       (fp_len),
        .ch_rd_burst_addr      (fp_addr),
        .ch_rd_burst_data_valid(fp_ch_valid),
        .ch_rd_burst_data      (fp_ch_data),
        .ch_rd_burst_finish    (fp_ch_finish),
        .ch_rd_burst_timeout   (fp_ch_timeout),
        .grant                 (fp_grant),
        .busy                  (fp_busy),
        .rd_burst_req          (fp_rd_burst_req),
        .rd_burst_len          (fp_rd_burst_len),
        .rd_burst_addr         (fp_rd_burst_addr),
        .rd_burst_data_valid   (fp_mem_valid),
        .rd_burst_data         (fp_mem_data),
        .rd_burst_finish       (fp_mem_finish)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int fin0_cnt = 0;

    always @(negedge mem_clk) begin
        if (rr_ch_finish[0]) fin0_cnt <= fin0_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    function automatic logic [22:0] addr_of(input int ch);
        return 23'(ch * 32'h1111 + 32'h40);
    endfunction

    task automatic set_rr_ch(input int ch, input logic req, input int len);
        rr_req[ch]           = req;
        rr_len[ch*10 +: 10]  = 10'(len);
        rr_addr[ch*23 +: 23] = addr_of(ch);
    endtask

    task automatic wait_rr_req(input string tag);
        int n = 0;
        while (!rr_rd_burst_req && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, 256'(rr_rd_burst_req), 256'(1));
    endtask

    // Controller model: valids for len cycles from the first req cycle,
    // finish 20 cycles after the req was first seen.
    task automatic serve_rr(input int ch, input int len);
        logic [255:0] exp_data;
        int nvalid = 0;
        wait_rr_req("rr_req_seen");
        check_eq("rr_grant", 256'(rr_grant), 256'(1 << ch));
        check_eq("rr_len", 256'(rr_rd_burst_len), 256'(len));
        check_eq("rr_addr", 256'(rr_rd_burst_addr), 256'(addr_of(ch)));
        for (int c = 0; c < 20; c++) begin
            rr_mem_valid = (c < len);
            rr_mem_data  = {8'hA5, 8'(ch), 16'(c)};
            #1;
            nvalid += int'(rr_ch_valid[ch]);
            if (c == 3) begin
                exp_data = '0;
                exp_data[ch*32 +: 32] = rr_mem_data;
                check_eq("rr_route_data", 256'(rr_ch_data), exp_data);
                check_eq("rr_route_valid", 256'(rr_ch_valid), 256'(1 << ch));
                check_eq("rr_req_clear", 256'(rr_rd_burst_req), 256'(0));
            end
            tick();
        end
        rr_mem_valid  = 1'b0;
        rr_mem_finish = 1'b1;
        tick();
        rr_mem_finish = 1'b0;
        check_eq("rr_finish_pulse", 256'(rr_ch_finish), 256'(1 << ch));
        check_eq("rr_valid_count", 256'(nvalid), 256'(len));
        tick();
        check_eq("rr_finish_one_cycle", 256'(rr_ch_finish), 256'(0));
    endtask

    initial begin
        int n;
        int fin0_before;
        rst_n = 1'b0;
        rr_req = '0; rr_len = '0; rr_addr = '0;
        rr_mem_valid = 1'b0; rr_mem_finish = 1'b0; rr_mem_data = '0;
        fp_req = '0; fp_len = '0; fp_addr = '0;
        fp_mem_valid = 1'b0; fp_mem_finish = 1'b0; fp_mem_data = '0;
        repeat (3) @(posedge mem_clk);
        #1;

        // Reset state
        check_eq("rst_grant", 256'(rr_grant), 256'(0));
        check_eq("rst_busy", 256'(rr_busy), 256'(0));
        check_eq("rst_req", 256'(rr_rd_burst_req), 256'(0));
        check_eq("rst_len_addr", 256'({rr_rd_burst_len, rr_rd_burst_addr}), 256'(0));
        check_eq("rst_ch_outs", 256'({rr_ch_valid, rr_ch_finish, rr_ch_timeout}), 256'(0));
        check_eq("rst_ch_data", 256'(rr_ch_data), 256'(0));
        check_eq("rst_fp_grant", 256'(fp_grant), 256'(0));
        rst_n = 1'b1;
        tick();
        tick();

        // Round-robin fairness: 0, 2, 5 requesting with len 16
        set_rr_ch(0, 1'b1, 16);
        set_rr_ch(2, 1'b1, 16);
        set_rr_ch(5, 1'b1, 16);
        for (int r = 0; r < 2; r++) begin
            serve_rr(0, 16);
            serve_rr(2, 16);
            serve_rr(5, 16);
        end
        rr_req = '0;

        // Controller inputs are ignored while arbitrating
        rr_mem_valid  = 1'b1;
        rr_mem_finish = 1'b1;
        #1;
        check_eq("arb_valid_ignored", 256'(rr_ch_valid), 256'(0));
        tick();
        check_eq("arb_finish_ignored", 256'(rr_ch_finish), 256'(0));
        check_eq("arb_not_busy", 256'(rr_busy), 256'(0));
        rr_mem_valid  = 1'b0;
        rr_mem_finish = 1'b0;
        tick();

        // Fixed priority: 1 beats 3 until 1 drops
        fp_len = {FP_CH{10'd4}};
        fp_addr = {FP_CH{23'h000777}};
        fp_req = 4'b1010;
        for (int it = 0; it < 3; it++) begin
            n = 0;
            while (!fp_rd_burst_req && n < 20) begin
                tick();
                n++;
            end
            check_eq("fp_req_seen", 256'(fp_rd_burst_req), 256'(1));
            check_eq("fp_grant_ch1", 256'(fp_grant), 256'(4'b0010));
            if (it == 2) fp_req = 4'b1000;
            fp_mem_finish = 1'b1;
            tick();
            fp_mem_finish = 1'b0;
            check_eq("fp_finish_ch1", 256'(fp_ch_finish), 256'(4'b0010));
        end
        n = 0;
        while (!fp_rd_burst_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("fp_grant_ch3", 256'(fp_grant), 256'(4'b1000));
        fp_mem_finish = 1'b1;
        tick();
        fp_mem_finish = 1'b0;
        fp_req = '0;
        tick();

        // Zero-length skip plus exact request latency
        fin0_before = fin0_cnt;
        set_rr_ch(0, 1'b1, 0);
        set_rr_ch(4, 1'b1, 8);
        tick();
        check_eq("zl_begin_busy", 256'(rr_busy), 256'(1));
        check_eq("zl_begin_grant", 256'(rr_grant), 256'(1 << 4));
        check_eq("zl_begin_noreq", 256'(rr_rd_burst_req), 256'(0));
        tick();
        check_eq("zl_req_latency", 256'(rr_rd_burst_req), 256'(1));
        serve_rr(4, 8);
        rr_req = '0;
        tick();
        check_eq("zl_no_fin0", 256'(fin0_cnt - fin0_before), 256'(0));

        // Watchdog abort on channel 1, then channel 2 granted next
        set_rr_ch(1, 1'b1, 4);
        set_rr_ch(2, 1'b1, 6);
        tick();
        check_eq("wd_grant_ch1", 256'(rr_grant), 256'(1 << 1));
        repeat (100) tick();
        check_eq("wd_not_early", 256'(rr_ch_timeout), 256'(0));
        check_eq("wd_req_held", 256'(rr_rd_burst_req), 256'(1));
        tick();
        check_eq("wd_timeout_pulse", 256'(rr_ch_timeout), 256'(1 << 1));
        check_eq("wd_req_dropped", 256'(rr_rd_burst_req), 256'(0));
        check_eq("wd_no_finish", 256'(rr_ch_finish), 256'(0));
        check_eq("wd_grant_clear", 256'(rr_grant), 256'(0));
        rr_req[1] = 1'b0;
        tick();
        check_eq("wd_pulse_end", 256'(rr_ch_timeout), 256'(0));
        check_eq("wd_next_grant", 256'(rr_grant), 256'(1 << 2));

        // Finish on the watchdog's last cycle wins
        repeat (100) tick();
        check_eq("col_req_held", 256'(rr_rd_burst_req), 256'(1));
        rr_mem_finish = 1'b1;
        tick();
        rr_mem_finish = 1'b0;
        rr_req[2] = 1'b0;
        check_eq("col_finish", 256'(rr_ch_finish), 256'(1 << 2));
        check_eq("col_no_timeout", 256'(rr_ch_timeout), 256'(0));
        tick();
        check_eq("col_no_late_timeout", 256'(rr_ch_timeout), 256'(0));
        check_eq("col_grant_clear", 256'(rr_grant), 256'(0));

        // Reset during READ, then channel 0 first afterwards
        set_rr_ch(0, 1'b1, 5);
        set_rr_ch(3, 1'b1, 5);
        wait_rr_req("mr_req_seen");
        check_eq("mr_grant_ch3", 256'(rr_grant), 256'(1 << 3));
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mr_grant_zero", 256'(rr_grant), 256'(0));
        check_eq("mr_req_zero", 256'(rr_rd_burst_req), 256'(0));
        check_eq("mr_busy_zero", 256'(rr_busy), 256'(0));
        check_eq("mr_pulses_zero", 256'({rr_ch_finish, rr_ch_timeout}), 256'(0));
        tick();
        rst_n = 1'b1;
        n = 0;
        while (rr_grant == '0 && n < 10) begin
            tick();
            n++;
        end
        check_eq("mr_first_grant_ch0", 256'(rr_grant), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
